// File: rtl/fp_io_sequencer.sv
// Byte-serial front/back end for the single-precision add/sub stage: gathers a
// command byte and two LSB-first operands, registers the result, streams it out.
module fp_io_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 0,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ena,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        op_sub,
    input  logic [31:0] fp_result,
    output logic        busy,
    output logic        err_pulse
);

    typedef enum logic [2:0] {
        S_CMD,
        S_LDA,
        S_LDB,
        S_EXEC,
        S_SEND
    } state_t;

    localparam logic [CNT_W-1:0] TO_LAST =
        (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [1:0]       byte_idx;
    logic [31:0]      res_q;
    logic [CNT_W-1:0] to_cnt;
    logic             accept, send, loading, timeout_hit;

    assign busy     = (state != S_CMD);
    assign out_data = res_q[{byte_idx, 3'b000} +: 8];

    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        loading     = 1'b0;
        case (state)
            S_CMD:        in_ready = 1'b1;
            S_LDA, S_LDB: begin
                in_ready = 1'b1;
                loading  = 1'b1;
            end
            S_SEND:       out_valid = 1'b1;
            default:      ;
        endcase

        accept = ena & in_valid & in_ready;
        send   = ena & out_valid & out_ready;
        // An accept on the terminal count takes priority over the abort.
        timeout_hit = (TIMEOUT_CYCLES != 0) && loading && ena && !accept
                      && (to_cnt == TO_LAST);

        case (state)
            S_CMD:  if (accept) state_nxt = S_LDA;
            S_LDA: begin
                if (accept && byte_idx == 2'd3) state_nxt = S_LDB;
                else if (timeout_hit)           state_nxt = S_CMD;
            end
            S_LDB: begin
                if (accept && byte_idx == 2'd3) state_nxt = S_EXEC;
                else if (timeout_hit)           state_nxt = S_CMD;
            end
            S_EXEC: if (ena) state_nxt = S_SEND;
            S_SEND: if (send && byte_idx == 2'd3) state_nxt = S_CMD;
            default: state_nxt = S_CMD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_CMD;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx  <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sub    <= 1'b0;
            res_q     <= '0;
            to_cnt    <= '0;
            err_pulse <= 1'b0;
        end else if (ena) begin
            err_pulse <= timeout_hit;
            if (loading && !accept && !timeout_hit) to_cnt <= to_cnt + 1'b1;
            else                                    to_cnt <= '0;

            case (state)
                S_CMD: if (accept) begin
                    op_sub   <= in_data[0];
                    byte_idx <= '0;
                end
                S_LDA: begin
                    if (accept) begin
                        op_a[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                    end else if (timeout_hit) begin
                        byte_idx <= '0;
                    end
                end
                S_LDB: begin
                    if (accept) begin
                        op_b[{byte_idx, 3'b000} +: 8] <= in_data;
                        byte_idx <= byte_idx + 2'd1;
                    end else if (timeout_hit) begin
                        byte_idx <= '0;
                    end
                end
                S_EXEC: begin
                    res_q    <= fp_result;
                    byte_idx <= '0;
                end
                S_SEND: if (send) byte_idx <= byte_idx + 2'd1;
                default: ;
            endcase
        end else begin
            err_pulse <= 1'b0;
        end
    end

endmodule
